// File: rtl/irq_pending_latch.sv
// Per-source interrupt pending latch: captures requests (edge or level), clears on ack,
// masks at the output only, and records requests lost while still pending.
module irq_pending_latch #(
    parameter int EDGE_MODE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq,
    input  logic [3:0] mask,
    input  logic       ack_valid,
    input  logic [1:0] ack_id,
    input  logic       ovf_clr,
    output logic [3:0] pend_vec,
    output logic       irq_any,
    output logic [3:0] ovf
);

    logic [3:0] pending;
    logic [3:0] irq_prev;
    logic [3:0] set_v;
    logic [3:0] clr_v;
    logic [3:0] lost_v;

    always_comb begin
        set_v  = (EDGE_MODE != 0) ? (irq & ~irq_prev) : irq;
        clr_v  = 4'b0000;
        if (ack_valid) begin
            clr_v[ack_id] = 1'b1;
        end
        // A new edge on a bit being acked in the same cycle re-arms it; not a loss.
        lost_v = (EDGE_MODE != 0) ? (set_v & pending & ~clr_v) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 4'b0000;
            irq_prev <= 4'b0000;
            ovf      <= 4'b0000;
        end else begin
            pending  <= set_v | (pending & ~clr_v);
            irq_prev <= irq;
            ovf      <= (ovf_clr ? 4'b0000 : ovf) | lost_v;
        end
    end

    // Mask gates visibility only, so a masked request appears as soon as it is unmasked.
    assign pend_vec = pending & mask;
    assign irq_any  = |pend_vec;

endmodule
